// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: bundles the register-file bus between decode/writeback
// (master) and the register file (slave).
//   write   : wr_en, wr_addr, wr_data                   (master -> slave)
//   read    : rd_addr1, rd_addr2, imm_sel               (master -> slave)
//             rd_data1, rd_data2                        (slave -> master)
//   issue   : iss_en, iss_addr                          (master -> slave)
//             busy1, busy2                              (slave -> master)
//   dump    : dump_start, dump_ready                    (master -> slave)
//             dump_valid, dump_addr, dump_data, dump_done (slave -> master)
interface reg_file_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic              imm_sel;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_addr;
   logic              busy1;
   logic              busy2;
   logic              dump_start;
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W-1:0] dump_addr;
   logic [DATA_W-1:0] dump_data;
   logic              dump_done;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, imm_sel,
             iss_en, iss_addr, dump_start, dump_ready,
      input  rd_data1, rd_data2, busy1, busy2,
             dump_valid, dump_addr, dump_data, dump_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, imm_sel,
             iss_en, iss_addr, dump_start, dump_ready,
      output rd_data1, rd_data2, busy1, busy2,
             dump_valid, dump_addr, dump_data, dump_done
   );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with write-through bypass,
// per-register busy scoreboard and a valid/ready register dump stream.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears array, scoreboard and dump
//   bus   : reg_file_sb_if slave modport (write, read, issue, dump groups)
module reg_file_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic          clk,
   input  logic          reset,
   reg_file_sb_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] dump_data_q, dump_data_d;
   logic              load;
   logic [ADDR_W-1:0] load_addr;
   logic              wr_ok, iss_ok;
   logic [DATA_W-1:0] rd1, rd2;

   // With ZERO_REG, register 0 is hard-wired: no write, no busy, no bypass.
   assign wr_ok  = bus.wr_en  && !(ZERO_REG != 0 && bus.wr_addr  == '0);
   assign iss_ok = bus.iss_en && !(ZERO_REG != 0 && bus.iss_addr == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else if (wr_ok) begin
         regs_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      rd1 = regs_q[bus.rd_addr1];
      if (wr_ok && bus.wr_addr == bus.rd_addr1) rd1 = bus.wr_data;
      rd2 = regs_q[bus.rd_addr2];
      if (wr_ok && bus.wr_addr == bus.rd_addr2) rd2 = bus.wr_data;
      // Immediate operand replaces port 2 entirely, bypass included.
      if (bus.imm_sel) rd2 = DATA_W'(bus.rd_addr2);
      if (!reset) begin
         rd1 = '0;
         rd2 = '0;
      end
   end

   assign bus.rd_data1 = rd1;
   assign bus.rd_data2 = rd2;

   // Clear first, then set: an issue to the register being written back
   // belongs to a newer producer and must stay pending.
   always_comb begin
      busy_d = busy_q;
      if (bus.wr_en) busy_d[bus.wr_addr]  = 1'b0;
      if (iss_ok)    busy_d[bus.iss_addr] = 1'b1;
   end

   // A write landing this cycle is bypassed, so it resolves the stall now.
   assign bus.busy1 = busy_q[bus.rd_addr1] & ~(bus.wr_en & (bus.wr_addr == bus.rd_addr1));
   assign bus.busy2 = ~bus.imm_sel & busy_q[bus.rd_addr2]
                    & ~(bus.wr_en & (bus.wr_addr == bus.rd_addr2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q      <= '0;
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         dump_data_q <= '0;
      end else begin
         busy_q      <= busy_d;
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         dump_data_q <= dump_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.dump_start) state_d = S_SEND;
         S_SEND:  if (bus.dump_ready && ptr_q == '1) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.dump_valid = 1'b0;
      bus.dump_done  = 1'b0;
      load           = 1'b0;
      load_addr      = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.dump_start) begin
               load      = 1'b1;
               load_addr = '0;
            end
         end
         S_SEND: begin
            bus.dump_valid = 1'b1;
            // Next beat loads on the accepting edge, so beats run back to back.
            if (bus.dump_ready && ptr_q != '1) begin
               load      = 1'b1;
               load_addr = ptr_q + ADDR_W'(1);
            end
         end
         S_DONE:  bus.dump_done = 1'b1;
         default: ;
      endcase
   end

   // Beat data is captured from the array as it stands before this edge's write.
   assign ptr_d       = load ? load_addr : ptr_q;
   assign dump_data_d = load ? regs_q[load_addr] : dump_data_q;

   assign bus.dump_addr = ptr_q;
   assign bus.dump_data = dump_data_q;
endmodule
